// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and constants for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0]          word_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

  // Architectural x0: reads as zero, never written, never pending
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard with per-read-port lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    lk_pending
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  // Retire clears, issue sets afterwards so it wins on a same-address collision; x0 never pends
  always_comb begin
    pending_nxt = pending;
    if (wr_en) begin
      pending_nxt[wr_addr] = 1'b0;
    end
    if (iss_en) begin
      pending_nxt[iss_addr] = 1'b1;
    end
    pending_nxt[ZERO_REG] = 1'b0;
  end

  // Pending vector; reset discards every in-flight issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Pre-edge pending state for each read port's address, x0 masked explicitly
  always_comb begin
    lk_pending = '0;
    for (int i = 0; i < NRD; i++) begin
      lk_pending[i] = (rd_addr[i*AW +: AW] != AW'(ZERO_REG)) && pending[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read/1-write register file with scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] regs      [NREGS];
  logic [XLEN-1:0] rd_word   [NRD];
  logic [XLEN-1:0] rd_data_q [NRD];
  logic [NRD-1:0]  rd_pend_nxt;
  logic [NRD-1:0]  rd_pending_q;
  logic [NRD-1:0]  sb_pending;
  logic [XLEN-1:0] dbg_word;
  logic [XLEN-1:0] dbg_data_q;
  logic            wr_hit;

  // A write to x0 is dropped entirely, both for storage and for the scoreboard
  assign wr_hit = wr_en && (wr_addr != AW'(ZERO_REG));

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .wr_en      (wr_hit),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .lk_pending (sb_pending)
  );

  // Storage array; x0 is never written so it keeps its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Value and pending bit each read port captures at the next edge
  always_comb begin
    rd_pend_nxt = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_word[i]     = regs[rd_addr[i*AW +: AW]];
      rd_pend_nxt[i] = sb_pending[i];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (rd_addr[i*AW +: AW] == wr_addr)) begin
        rd_word[i]     = wr_data;
        rd_pend_nxt[i] = iss_en && (iss_addr == wr_addr);
      end
`endif
    end
  end

  // Debug lookup, forwarded the same way as the read ports when bypass is built in
  always_comb begin
    dbg_word = regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (dbg_addr == wr_addr)) begin
      dbg_word = wr_data;
    end
`endif
  end

  // Registered read ports; a port with its enable low holds its last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRD; i++) begin
        rd_data_q[i] <= '0;
      end
      rd_pending_q <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data_q[i]    <= rd_word[i];
          rd_pending_q[i] <= rd_pend_nxt[i];
        end
      end
    end
  end

  // Debug port samples every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= dbg_word;
    end
  end

  // Pack per-port results onto the flat output buses
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = rd_data_q[i];
    end
  end

  assign rd_pending = rd_pending_q;
  assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with a behavioural array model
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  logic [XLEN-1:0] exp_data [NRD];
  bit              exp_pend [NRD];
  logic [XLEN-1:0] exp_dbg;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [XLEN-1:0] rdd(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic idle();
    rd_en    = '0;
    rd_addr  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    dbg_addr = '0;
  endtask

  task automatic set_rd(input int p, input bit en, input int a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int a, input logic [XLEN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic set_iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = '0;
      m_pend[k] = 0;
    end
    for (int p = 0; p < NRD; p++) begin
      exp_data[p] = '0;
      exp_pend[p] = 0;
    end
    exp_dbg = '0;
  endtask

  // Apply the current inputs for one clock: predict outputs from the architectural rules, then advance
  task automatic tick();
    bit              wrote;
    logic [AW-1:0]   a;
    wrote = wr_en && (wr_addr != 0);
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*AW +: AW];
        exp_data[p] = m_regs[a];
        exp_pend[p] = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (wrote && a == wr_addr) begin
          exp_data[p] = wr_data;
          exp_pend[p] = iss_en && (iss_addr == wr_addr);
        end
`endif
      end
    end
    exp_dbg = m_regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
    if (wrote && dbg_addr == wr_addr) exp_dbg = wr_data;
`endif
    if (wrote) begin
      m_regs[wr_addr] = wr_data;
      m_pend[wr_addr] = 0;
    end
    if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int p = 0; p < NRD; p++) begin
      n_checks++;
      if (rdd(p) !== '0 || rd_pending[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold port%0d data=%h pend=%b expected 0/0", p, rdd(p), rd_pending[p]);
      end
    end
    n_checks++;
    if (dbg_data !== '0) begin
      n_fail++;
      $display("FAIL reset_hold dbg=%h expected 0", dbg_data);
    end
    rst_n = 1'b1;
    for (int a = 1; a < NREGS; a++) begin
      set_rd(0, 1, a);
      set_rd(1, 1, a);
      dbg_addr = AW'(a);
      tick();
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (rdd(p) !== '0 || rd_pending[p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read x%0d port%0d data=%h pend=%b expected 0/0", a, p, rdd(p), rd_pending[p]);
        end
      end
      n_checks++;
      if (dbg_data !== '0) begin
        n_fail++;
        $display("FAIL reset_read dbg x%0d got %h expected 0", a, dbg_data);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    set_wr(5, 32'hDEADBEEF);
    tick();
    idle();
    set_rd(0, 1, 5);
    set_rd(1, 1, 0);
    dbg_addr = 5;
    tick();
    n_checks++;
    if (rdd(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read port0 got %h expected deadbeef", rdd(0));
    end
    n_checks++;
    if (rdd(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL write_read port1 x0 got %h expected 0", rdd(1));
    end
    n_checks++;
    if (dbg_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read dbg got %h expected deadbeef", dbg_data);
    end
  endtask

  task automatic test_x0();
    idle();
    set_wr(0, 32'h1234);
    set_iss(0);
    tick();
    idle();
    set_rd(0, 1, 0);
    set_rd(1, 1, 0);
    tick();
    for (int p = 0; p < NRD; p++) begin
      n_checks++;
      if (rdd(p) !== '0 || rd_pending[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL x0 port%0d data=%h pend=%b expected 0/0", p, rdd(p), rd_pending[p]);
      end
    end
  endtask

  task automatic test_pending();
    idle();
    set_iss(7);
    tick();
    idle();
    set_rd(0, 1, 7);
    set_rd(1, 1, 8);
    tick();
    n_checks++;
    if (rd_pending[0] !== 1'b1 || rdd(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL pend_issue x7 pend=%b data=%h expected 1/0", rd_pending[0], rdd(0));
    end
    n_checks++;
    if (rd_pending[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_issue x8 pend=%b expected 0", rd_pending[1]);
    end
    idle();
    set_wr(7, 32'h55);
    tick();
    idle();
    set_rd(0, 1, 7);
    tick();
    n_checks++;
    if (rd_pending[0] !== 1'b0 || rdd(0) !== 32'h55) begin
      n_fail++;
      $display("FAIL pend_retire x7 pend=%b data=%h expected 0/55", rd_pending[0], rdd(0));
    end
    idle();
    set_iss(7);
    set_wr(7, 32'h66);
    tick();
    idle();
    set_rd(0, 1, 7);
    tick();
    n_checks++;
    if (rd_pending[0] !== 1'b1 || rdd(0) !== 32'h66) begin
      n_fail++;
      $display("FAIL pend_collide x7 pend=%b data=%h expected 1/66", rd_pending[0], rdd(0));
    end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] want;
    bit              want_p;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h0;
`endif
    idle();
    set_wr(9, 32'hA5A5A5A5);
    set_rd(0, 1, 9);
    set_rd(1, 1, 9);
    dbg_addr = 9;
    tick();
    for (int p = 0; p < NRD; p++) begin
      n_checks++;
      if (rdd(p) !== want || rd_pending[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL same_cycle x9 port%0d data=%h pend=%b expected %h/0", p, rdd(p), rd_pending[p], want);
      end
    end
    n_checks++;
    if (dbg_data !== want) begin
      n_fail++;
      $display("FAIL same_cycle dbg got %h expected %h", dbg_data, want);
    end
    idle();
    set_rd(0, 1, 9);
    tick();
    n_checks++;
    if (rdd(0) !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL same_cycle_after x9 got %h expected a5a5a5a5", rdd(0));
    end
    // issue+write+read of one register in a single cycle
`ifdef REGFILE_BYPASS_EN
    want   = 32'h0BAD0BAD;
    want_p = 1;
`else
    want   = 32'h0;
    want_p = 0;
`endif
    idle();
    set_iss(10);
    set_wr(10, 32'h0BAD0BAD);
    set_rd(1, 1, 10);
    tick();
    n_checks++;
    if (rdd(1) !== want || rd_pending[1] !== want_p) begin
      n_fail++;
      $display("FAIL same_cycle_iss x10 data=%h pend=%b expected %h/%b", rdd(1), rd_pending[1], want, want_p);
    end
  endtask

  task automatic test_hold();
    idle();
    set_rd(0, 1, 5);
    set_rd(1, 1, 7);
    tick();
    idle();
    set_rd(0, 0, 3);
    set_rd(1, 0, 0);
    set_wr(5, 32'h11);
    tick();
    tick();
    n_checks++;
    if (rdd(0) !== 32'hDEADBEEF || rdd(1) !== 32'h66 || rd_pending !== 2'b10) begin
      n_fail++;
      $display("FAIL hold data0=%h data1=%h pend=%b expected deadbeef/66/10", rdd(0), rdd(1), rd_pending);
    end
  endtask

  task automatic test_async_reset();
    idle();
    set_wr(3, 32'h77);
    tick();
    idle();
    set_rd(0, 1, 3);
    dbg_addr = 3;
    tick();
    n_checks++;
    if (rdd(0) !== 32'h77 || dbg_data !== 32'h77) begin
      n_fail++;
      $display("FAIL async_pre data=%h dbg=%h expected 77/77", rdd(0), dbg_data);
    end
    #2;
    rst_n = 1'b0;
    set_wr(3, 32'h99);
    #1;
    n_checks++;
    if (rdd(0) !== '0 || dbg_data !== '0 || rd_pending !== '0) begin
      n_fail++;
      $display("FAIL async_clear data=%h dbg=%h pend=%b expected 0/0/0", rdd(0), dbg_data, rd_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    model_reset();
    set_rd(0, 1, 3);
    set_rd(1, 1, 7);
    dbg_addr = 3;
    tick();
    n_checks++;
    if (rdd(0) !== '0 || dbg_data !== '0) begin
      n_fail++;
      $display("FAIL async_after x3 data=%h dbg=%h expected 0/0", rdd(0), dbg_data);
    end
    n_checks++;
    if (rdd(1) !== '0 || rd_pending[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_after x7 data=%h pend=%b expected 0/0", rdd(1), rd_pending[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < NRD; p++) begin
        set_rd(p, bit'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS-1)) : int'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 2) == 0) set_iss(int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) set_wr(int'($urandom_range(0, 7)), $urandom);
      dbg_addr = AW'($urandom_range(0, 7));
      tick();
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (rdd(p) !== exp_data[p] || rd_pending[p] !== exp_pend[p]) begin
          n_fail++;
          $display("FAIL random cyc%0d port%0d data=%h pend=%b expected %h/%b",
                   n, p, rdd(p), rd_pending[p], exp_data[p], exp_pend[p]);
        end
      end
      n_checks++;
      if (dbg_data !== exp_dbg) begin
        n_fail++;
        $display("FAIL random cyc%0d dbg got %h expected %h", n, dbg_data, exp_dbg);
      end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_x0();
    test_pending();
    test_same_cycle();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
